reciprocal_seq: RTL and testbench

RECIPROCAL_SEQ -- requirements
Module: reciprocal_seq

---
 rtl/reciprocal_seq_if.sv | 17 +
 rtl/reciprocal_seq.sv | 162 ++++++++++++++++
 tb/tb_reciprocal_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/reciprocal_seq_if.sv
// reciprocal_seq_if: operand/result handshake bundle for the sequential reciprocal unit
interface reciprocal_seq_if #(
  parameter int NEXP = 8,
  parameter int NSIG = 7
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NEXP+NSIG:0]   A;
  logic [1:0]           rm;
  logic                 out_valid;
  logic                 out_ready;
  logic [NEXP+NSIG:0]   Arecip;
  logic [5:0]           recipFlags;
  logic [4:0]           excFlags;
  modport master (output in_valid, A, rm, out_ready, input in_ready, out_valid, Arecip, recipFlags, excFlags);
  modport slave (input in_valid, A, rm, out_ready, output in_ready, out_valid, Arecip, recipFlags, excFlags);
endinterface

// File: rtl/reciprocal_seq.sv
// reciprocal_seq: sequential IEEE-style reciprocal via restoring division with full rounding
module reciprocal_seq #(
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic             clk,
  input  logic             rst,
  reciprocal_seq_if.slave  bus
);
  localparam int W    = NEXP + NSIG + 1;
  localparam int EW   = NEXP + 2;
  localparam int QW   = NSIG + 2;
  localparam int RW   = NSIG + 3;
  localparam int CW   = $clog2(NSIG + 3);
  localparam int BIAS = (1 << (NEXP - 1)) - 1;
  typedef enum logic [2:0] {IDLE, NORM, DIV, ROUND, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0]    a_q, res_q;
  logic [1:0]      rm_q;
  logic [NSIG:0]   m_q;
  logic [EW-1:0]   exp_q;
  logic            pow2_q, spec_q;
  logic [RW-1:0]   r_q;
  logic [QW-1:0]   quo_q;
  logic [CW-1:0]   cnt_q;
  logic [5:0]      cls_q;
  logic [4:0]      exc_q;
  logic            s, e_max, e_zero, f_zero, nan, inf, zer, spec, pow2;
  logic [NEXP-1:0] ae;
  logic [NSIG-1:0] af, nf;
  logic [EW-1:0]   ne, exp_n;
  logic [W-1:0]    spec_res;
  logic [5:0]      spec_cls;
  logic [4:0]      spec_exc;
  assign {s, ae, af} = a_q;
  assign e_max  = &ae;
  assign e_zero = ae == '0;
  assign f_zero = af == '0;
  assign nan    = e_max & ~f_zero;
  assign inf    = e_max & f_zero;
  assign zer    = e_zero & f_zero;
  assign spec   = e_max | zer;
  // subnormals: shift the leading one into the hidden position and lower the exponent to match
  always_comb begin
    nf = af;
    ne = {2'b00, ae};
    if (e_zero)
      for (int i = 0; i < NSIG; i++)
        if (af[i]) begin
          nf = af << (NSIG - i);
          ne = EW'(i + 1 - NSIG);
        end
  end
  assign pow2     = nf == '0;
  assign exp_n    = EW'(2 * BIAS) - ne - {{(EW-1){1'b0}}, ~pow2};
  assign spec_res = nan ? {s, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}} : inf ? {s, {(W-1){1'b0}}} : {s, {NEXP{1'b1}}, {NSIG{1'b0}}};
  assign spec_cls = nan ? 6'h10 : inf ? 6'h04 : 6'h08;
  assign spec_exc = nan ? {4'b0000, ~af[NSIG-1]} : inf ? 5'h00 : 5'h02;
  logic            ge;
  logic [RW-1:0]   m_ext, r_nxt;
  assign m_ext = {2'b00, m_q};
  assign ge    = r_q >= m_ext;
  assign r_nxt = (ge ? r_q - m_ext : r_q) << 1;
  logic [QW-1:0]      q, qs, lostm;
  logic [EW-1:0]      sh, rexp;
  logic [EW+NSIG-1:0] ef;
  logic [NSIG-1:0]    rfrac;
  logic               rs, tiny, st, g, inx, inc, ovf, ovf_inf;
  logic [W-1:0]       rnd_res;
  logic [5:0]         rnd_cls;
  logic [4:0]         rnd_exc;
  assign rs = a_q[W-1];
  // denormalise tiny results, round per rm, and let the carry ripple into the exponent field
  always_comb begin
    q       = pow2_q ? {1'b1, {(QW-1){1'b0}}} : quo_q;
    tiny    = exp_q[EW-1] | (exp_q == '0);
    sh      = tiny ? EW'(1) - exp_q : '0;
    qs      = q >> sh;
    lostm   = q & ~({QW{1'b1}} << sh);
    st      = (~pow2_q & (|r_q)) | (|lostm);
    g       = qs[0];
    inx     = g | st;
    inc     = rm_q == 2'd0 ? g & (st | qs[1]) : rm_q == 2'd1 ? 1'b0 : rm_q == 2'd2 ? ~rs & inx : rs & inx;
    ef      = {tiny ? {EW{1'b0}} : exp_q, qs[NSIG:1]} + {{(EW+NSIG-1){1'b0}}, inc};
    rexp    = ef[EW+NSIG-1:NSIG];
    rfrac   = ef[NSIG-1:0];
    ovf     = rexp >= EW'((1 << NEXP) - 1);
    ovf_inf = (rm_q == 2'd0) | ((rm_q == 2'd2) & ~rs) | ((rm_q == 2'd3) & rs);
    rnd_res = ~ovf ? {rs, rexp[NEXP-1:0], rfrac} : ovf_inf ? {rs, {NEXP{1'b1}}, {NSIG{1'b0}}} : {rs, {(NEXP-1){1'b1}}, 1'b0, {NSIG{1'b1}}};
    rnd_cls = ovf ? (ovf_inf ? 6'h08 : 6'h01) : rexp == '0 ? (rfrac == '0 ? 6'h04 : 6'h02) : 6'h01;
    rnd_exc = {inx | ovf, tiny & inx, ovf, 2'b00};
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // next state and handshake outputs; specials pass through ROUND untouched to settle their result
  always_comb begin
    state_d        = state_q;
    bus.in_ready   = state_q == IDLE;
    bus.out_valid  = state_q == DONE;
    bus.Arecip     = res_q;
    bus.recipFlags = cls_q;
    bus.excFlags   = exc_q;
    case (state_q)
      IDLE:    state_d = bus.in_valid ? NORM : IDLE;
      NORM:    state_d = spec ? ROUND : DIV;
      DIV:     state_d = cnt_q == CW'(NSIG + 1) ? ROUND : DIV;
      ROUND:   state_d = DONE;
      DONE:    state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // operand capture, one quotient bit per DIV cycle, result capture
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q    <= '0;
      rm_q   <= '0;
      m_q    <= '0;
      exp_q  <= '0;
      pow2_q <= 1'b0;
      spec_q <= 1'b0;
      r_q    <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      cls_q  <= '0;
      exc_q  <= '0;
    end else
      case (state_q)
        IDLE:
          if (bus.in_valid) begin
            a_q  <= bus.A;
            rm_q <= bus.rm;
          end
        NORM: begin
          m_q    <= {1'b1, nf};
          exp_q  <= exp_n;
          pow2_q <= pow2;
          spec_q <= spec;
          r_q    <= {2'b01, {(NSIG+1){1'b0}}};
          cnt_q  <= '0;
          if (spec) begin
            res_q <= spec_res;
            cls_q <= spec_cls;
            exc_q <= spec_exc;
          end
        end
        DIV: begin
          r_q   <= r_nxt;
          quo_q <= {quo_q[QW-2:0], ge};
          cnt_q <= cnt_q + CW'(1);
        end
        ROUND:
          if (!spec_q) begin
            res_q <= rnd_res;
            cls_q <= rnd_cls;
            exc_q <= rnd_exc;
          end
        default: ;
      endcase
endmodule

// File: tb/tb_reciprocal_seq.sv
// tb_reciprocal_seq: directed-vector bench for reciprocal_seq (NEXP=8, NSIG=7)
module tb_reciprocal_seq;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  reciprocal_seq_if #(.NEXP(8), .NSIG(7)) bus ();
  reciprocal_seq #(.NEXP(8), .NSIG(7)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic [15:0] a;
    logic [1:0]  rm;
    logic [15:0] res;
    logic [5:0]  cls;
    logic [4:0]  exc;
    logic [3:0]  lat;
  } vec_t;
  vec_t vecs [20];
  task automatic do_op(input logic [15:0] a, input logic [1:0] r, output logic [15:0] res,
                       output logic [5:0] cls, output logic [4:0] exc, output int lat);
    int k = 0;
    while (!bus.in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    bus.A = a;
    bus.rm = r;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.A = ~a;
    bus.rm = ~r;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.Arecip;
    cls = bus.recipFlags;
    exc = bus.excFlags;
    if (bus.out_ready) begin
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.A = '0;
    bus.rm = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.Arecip !== 16'h0) begin bad++; $display("FAIL rst_arecip: got %h want 0000", bus.Arecip); end
    total++; if (bus.recipFlags !== 6'h0) begin bad++; $display("FAIL rst_class: got %h want 00", bus.recipFlags); end
    total++; if (bus.excFlags !== 5'h0) begin bad++; $display("FAIL rst_exc: got %h want 00", bus.excFlags); end
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
  endtask
  task automatic run_range(input int lo, input int hi);
    logic [15:0] res;
    logic [5:0] cls;
    logic [4:0] exc;
    int lat;
    for (int i = lo; i <= hi; i++) begin
      do_op(vecs[i].a, vecs[i].rm, res, cls, exc, lat);
      total++; if (res !== vecs[i].res) begin bad++; $display("FAIL vec%0d_res A=%h rm=%0d: got %h want %h", i, vecs[i].a, vecs[i].rm, res, vecs[i].res); end
      total++; if (cls !== vecs[i].cls) begin bad++; $display("FAIL vec%0d_class: got %h want %h", i, cls, vecs[i].cls); end
      total++; if (exc !== vecs[i].exc) begin bad++; $display("FAIL vec%0d_exc: got %h want %h", i, exc, vecs[i].exc); end
      total++; if (lat != int'(vecs[i].lat)) begin bad++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, vecs[i].lat); end
    end
  endtask
  task automatic test_finite;
    run_range(0, 13);
  endtask
  task automatic test_special;
    run_range(14, 19);
  endtask
  task automatic test_backpressure;
    logic [15:0] res;
    logic [5:0] cls;
    logic [4:0] exc;
    int lat;
    bus.out_ready = 1'b0;
    do_op(16'h4040, 2'd0, res, cls, exc, lat);
    total++; if (res !== 16'h3EAB) begin bad++; $display("FAIL bp_first_res: got %h want 3eab", res); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold%0d_hs: got valid=%b ready=%b want 1 0", c, bus.out_valid, bus.in_ready); end
      total++; if (bus.Arecip !== 16'h3EAB || bus.recipFlags !== 6'h01 || bus.excFlags !== 5'h10) begin bad++; $display("FAIL bp_hold%0d_data: got %h/%h/%h want 3eab/01/10", c, bus.Arecip, bus.recipFlags, bus.excFlags); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got valid=%b ready=%b want 0 1", bus.out_valid, bus.in_ready); end
  endtask
  task automatic test_reset_mid_div;
    logic [15:0] res;
    logic [5:0] cls;
    logic [4:0] exc;
    int lat;
    int seen = 0;
    bus.A = 16'h4040;
    bus.rm = 2'd0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL middiv_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.Arecip !== 16'h0 || bus.recipFlags !== 6'h0 || bus.excFlags !== 5'h0) begin bad++; $display("FAIL middiv_clear: got %h/%h/%h want 0/0/0", bus.Arecip, bus.recipFlags, bus.excFlags); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL middiv_in_ready: got %b want 1", bus.in_ready); end
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL middiv_no_result: got %0d valid cycles want 0", seen); end
    do_op(16'h4000, 2'd0, res, cls, exc, lat);
    total++; if (res !== 16'h3F00 || cls !== 6'h01 || exc !== 5'h00) begin bad++; $display("FAIL middiv_next_op: got %h/%h/%h want 3f00/01/00", res, cls, exc); end
    total++; if (lat != 11) begin bad++; $display("FAIL middiv_next_lat: got %0d want 11", lat); end
  endtask
  task automatic test_back_to_back;
    logic [15:0] res;
    logic [5:0] cls;
    logic [4:0] exc;
    int lat;
    do_op(16'h7F7F, 2'd0, res, cls, exc, lat);
    total++; if (res !== 16'h0020 || exc !== 5'h18) begin bad++; $display("FAIL b2b_first: got %h/%h want 0020/18", res, exc); end
    do_op(16'h0000, 2'd0, res, cls, exc, lat);
    total++; if (res !== 16'h7F80 || cls !== 6'h08 || lat != 2) begin bad++; $display("FAIL b2b_second: got %h/%h lat=%0d want 7f80/08 lat=2", res, cls, lat); end
    do_op(16'h4040, 2'd1, res, cls, exc, lat);
    total++; if (res !== 16'h3EAA || lat != 11) begin bad++; $display("FAIL b2b_third: got %h lat=%0d want 3eaa lat=11", res, lat); end
  endtask
  initial begin
    vecs = '{
      '{16'h4040, 2'd0, 16'h3EAB, 6'h01, 5'h10, 4'd11},
      '{16'h4040, 2'd1, 16'h3EAA, 6'h01, 5'h10, 4'd11},
      '{16'h4000, 2'd0, 16'h3F00, 6'h01, 5'h00, 4'd11},
      '{16'h3F80, 2'd0, 16'h3F80, 6'h01, 5'h00, 4'd11},
      '{16'h3FC0, 2'd0, 16'h3F2B, 6'h01, 5'h10, 4'd11},
      '{16'hC040, 2'd2, 16'hBEAA, 6'h01, 5'h10, 4'd11},
      '{16'hC040, 2'd3, 16'hBEAB, 6'h01, 5'h10, 4'd11},
      '{16'h0001, 2'd0, 16'h7F80, 6'h08, 5'h14, 4'd11},
      '{16'h0001, 2'd1, 16'h7F7F, 6'h01, 5'h14, 4'd11},
      '{16'h8001, 2'd3, 16'hFF80, 6'h08, 5'h14, 4'd11},
      '{16'h8001, 2'd2, 16'hFF7F, 6'h01, 5'h14, 4'd11},
      '{16'h7F7F, 2'd0, 16'h0020, 6'h02, 5'h18, 4'd11},
      '{16'h7E81, 2'd0, 16'h007F, 6'h02, 5'h18, 4'd11},
      '{16'h7E81, 2'd2, 16'h0080, 6'h01, 5'h18, 4'd11},
      '{16'h0000, 2'd0, 16'h7F80, 6'h08, 5'h02, 4'd2},
      '{16'h8000, 2'd0, 16'hFF80, 6'h08, 5'h02, 4'd2},
      '{16'h7F81, 2'd0, 16'h7FC0, 6'h10, 5'h01, 4'd2},
      '{16'h7FC0, 2'd0, 16'h7FC0, 6'h10, 5'h00, 4'd2},
      '{16'hFF80, 2'd0, 16'h8000, 6'h04, 5'h00, 4'd2},
      '{16'h7F80, 2'd0, 16'h0000, 6'h04, 5'h00, 4'd2}
    };
    test_reset;
    test_finite;
    test_special;
    test_backpressure;
    test_reset_mid_div;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
